// File: rtl/io_uart.sv
// io_uart: memory-mapped 8N1 UART peripheral on the CPU I/O window.
//   Two byte registers:
//     BASE_ADDR     DATA    read pops the RX FIFO; write pushes to the TX FIFO
//     BASE_ADDR+1   STATUS  {3'b0, framing_err, overrun, tx_idle, tx_not_full, rx_not_empty}
//   Ports:
//     i_clk, i_reset                  clock, synchronous active-high reset
//     i_ioNCE, i_ioNOE, i_ioNWE       active-low chip enable, read and write strobes
//     i_ioAddress, i_bus              I/O address and CPU write data
//     o_bus, o_busNOE                 read data and its active-low drive enable
//     i_rx, o_tx                      serial lines, both idle high
//     o_irqN                          active-low interrupt while RX data is waiting

module io_uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // The extra pointer MSB separates full from empty when the indices match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module io_uart #(
  parameter int         CLK_DIV    = 868,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] BASE_ADDR  = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ioNCE,
  input  logic [7:0] i_ioAddress,
  input  logic       i_ioNOE,
  input  logic       i_ioNWE,
  input  logic [7:0] i_bus,
  output logic [7:0] o_bus,
  output logic       o_busNOE,
  input  logic       i_rx,
  output logic       o_tx,
  output logic       o_irqN
);
  localparam int               CNT_W       = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [7:0]       STATUS_ADDR = BASE_ADDR + 8'd1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  logic       sel, rd, wr, rd_q, wr_q, rd_first, wr_first;
  logic       hit_data, hit_status, drive;
  logic [7:0] status;

  logic       tx_push, tx_pop, tx_empty, tx_full, tx_idle;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] rx_head;

  uart_state_t      tx_state, rx_state;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic [2:0]       tx_bit, rx_bit;
  logic [7:0]       tx_shift, rx_shift;
  logic             tx_line;
  logic             rx_s1, rx_s2, rx_prev;
  logic             rx_stop_now, set_overrun, set_framing, status_clear;
  logic             overrun, framing_err, irq_n;

  assign sel        = !i_ioNCE;
  assign rd         = sel & !i_ioNOE;
  assign wr         = sel & !i_ioNWE;
  assign hit_data   = (i_ioAddress == BASE_ADDR);
  assign hit_status = (i_ioAddress == STATUS_ADDR);

  // Side effects fire once per access; a simultaneous write suppresses the read
  assign rd_first = rd & !wr & !rd_q;
  assign wr_first = wr & !wr_q;

  assign drive    = !i_reset & rd & !wr & (hit_data | hit_status);
  assign tx_idle  = (tx_state == IDLE) & tx_empty;
  assign status   = {3'b000, framing_err, overrun, tx_idle, !tx_full, !rx_empty};
  assign o_busNOE = !drive;
  assign o_bus    = !drive ? 8'h00 : hit_status ? status : (rx_empty ? 8'h00 : rx_head);

  assign rx_pop       = rd_first & hit_data & !rx_empty;
  assign status_clear = rd_first & hit_status;
  assign tx_push      = wr_first & hit_data & !tx_full;

  // The TX FIFO is drained either from IDLE or straight out of a finishing stop bit
  assign tx_pop = !tx_empty & ((tx_state == IDLE) | ((tx_state == STOP) & (tx_cnt == BIT_LAST)));

  // A CPU pop in the same cycle frees the slot a full RX FIFO needs
  assign rx_stop_now = (rx_state == STOP) & (rx_cnt == BIT_LAST);
  assign rx_push     = rx_stop_now & rx_s2 & (!rx_full | rx_pop);
  assign set_overrun = rx_stop_now & rx_s2 & rx_full & !rx_pop;
  assign set_framing = rx_stop_now & !rx_s2;

  assign o_tx   = tx_line;
  assign o_irqN = irq_n;

  io_uart_fifo #(.DEPTH(FIFO_DEPTH)) tx_fifo (
    .clk(i_clk), .reset(i_reset), .push(tx_push), .pop(tx_pop), .din(i_bus),
    .head(tx_head), .empty(tx_empty), .full(tx_full)
  );

  io_uart_fifo #(.DEPTH(FIFO_DEPTH)) rx_fifo (
    .clk(i_clk), .reset(i_reset), .push(rx_push), .pop(rx_pop), .din(rx_shift),
    .head(rx_head), .empty(rx_empty), .full(rx_full)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
      irq_n       <= 1'b1;
    end else begin
      rd_q  <= rd;
      wr_q  <= wr;
      irq_n <= rx_empty;
      if (set_overrun)       overrun <= 1'b1;
      else if (status_clear) overrun <= 1'b0;
      if (set_framing)       framing_err <= 1'b1;
      else if (status_clear) framing_err <= 1'b0;
    end
  end

  // The line is a registered image of the state, so it trails the FSM by one cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_line <= (tx_state == START) ? 1'b0 : (tx_state == DATA) ? tx_shift[0] : 1'b1;
      case (tx_state)
        IDLE: begin
          if (tx_pop) begin
            tx_shift <= tx_head;
            tx_cnt   <= '0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= DATA;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b0, tx_shift[7:1]};
            if (tx_bit == 3'd7) tx_state <= STOP;
            else tx_bit <= tx_bit + 3'd1;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shift <= tx_head;
              tx_state <= START;
            end else tx_state <= IDLE;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // RX samples each bit near its centre: half a bit after the falling edge, then once per bit
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1   <= i_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        IDLE: begin
          if (rx_prev & !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? IDLE : DATA;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= STOP;
            else rx_bit <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= IDLE;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_uart.sv
module tb_io_uart;
  localparam int         CLK_DIV = 4;
  localparam int         DEPTH   = 16;
  localparam logic [7:0] BASE    = 8'h40;

  logic       clk = 1'b0;
  logic       reset;
  logic       nce, noe, nwe;
  logic [7:0] addr, wdata;
  logic [7:0] rdata;
  logic       bus_noe;
  logic       rx, tx, irq_n;

  int total = 0;
  int bad   = 0;

  logic [7:0] rd_exp_q[$];
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_model[$];
  bit         m_ov, m_fe;
  int         tx_gen = 0;

  io_uart #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_reset(reset), .i_ioNCE(nce), .i_ioAddress(addr),
    .i_ioNOE(noe), .i_ioNWE(nwe), .i_bus(wdata), .o_bus(rdata),
    .o_busNOE(bus_noe), .i_rx(rx), .o_tx(tx), .o_irqN(irq_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    nce = 1'b1; noe = 1'b1; nwe = 1'b1;
  endtask

  task automatic access(input logic [7:0] a, input bit is_write, input logic [7:0] d, input int hold);
    tick;
    nce  = 1'b0;
    addr = a;
    if (is_write) begin
      nwe   = 1'b0;
      wdata = d;
    end else noe = 1'b0;
    repeat (hold) tick;
    bus_idle;
  endtask

  task automatic write_data(input logic [7:0] d);
    tx_exp_q.push_back(d);
    access(BASE, 1'b1, d, 1);
  endtask

  task automatic read_data(input int hold);
    logic [7:0] e;
    e = (rx_model.size() != 0) ? rx_model.pop_front() : 8'h00;
    rd_exp_q.push_back(e);
    access(BASE, 1'b0, 8'h00, hold);
  endtask

  // TX is always quiet when STATUS is read, so txIdle and txNotFull are expected high
  task automatic read_status;
    rd_exp_q.push_back({3'b000, m_fe, m_ov, 1'b1, 1'b1, rx_model.size() != 0});
    m_fe = 1'b0;
    m_ov = 1'b0;
    access(BASE + 8'd1, 1'b0, 8'h00, 1);
  endtask

  task automatic send_rx(input logic [7:0] d, input bit stop);
    rx = 1'b0;
    repeat (CLK_DIV) tick;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CLK_DIV) tick;
    end
    rx = stop;
    repeat (CLK_DIV) tick;
    rx = 1'b1;
    repeat (6) tick;
    if (!stop) m_fe = 1'b1;
    else if (rx_model.size() < DEPTH) rx_model.push_back(d);
    else m_ov = 1'b1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tx_gen++;
    tx_exp_q.delete();
    rx_model.delete();
    m_ov = 1'b0;
    m_fe = 1'b0;
  endtask

  task automatic wait_tx_drain;
    int budget = 0;
    while (tx_exp_q.size() != 0 && budget < 3000) begin
      tick;
      budget++;
    end
    check("tx drain", tx_exp_q.size(), 0);
    repeat (5) tick;
  endtask

  // Read monitor: compares the first cycle of every driven read against the scoreboard
  initial begin
    logic prev = 1'b1;
    forever begin
      @(negedge clk);
      if (bus_noe === 1'b0 && prev) begin
        if (rd_exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected read: got %0h expected no drive", rdata);
        end else check("bus read", rdata, rd_exp_q.pop_front());
      end
      prev = (bus_noe !== 1'b0);
    end
  end

  // TX monitor: decodes frames at bit centres; frames cut short by reset are discarded
  initial begin
    logic [7:0] d;
    logic       start_ok, stop_bit;
    int         gen;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        gen = tx_gen;
        repeat (2) @(negedge clk);
        start_ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          d[i] = tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        stop_bit = tx;
        if (gen == tx_gen) begin
          if (tx_exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected tx frame: got %0h expected none", d);
          end else check("tx frame", {stop_bit, start_ok, d}, {2'b11, tx_exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] cap, expw;
    logic [7:0]  b;
    int          n;

    reset = 1'b1;
    rx    = 1'b1;
    addr  = 8'h00;
    wdata = 8'h00;
    bus_idle;
    repeat (3) tick;
    reset = 1'b0;

    @(negedge clk);
    check("reset tx", tx, 1'b1);
    check("reset irq", irq_n, 1'b1);
    check("reset busNOE", bus_noe, 1'b1);
    check("reset bus", rdata, 8'h00);
    read_status;

    // 0xA5 on the line: two quiet cycles after the write edge, then the frame
    b    = 8'hA5;
    expw = '0;
    repeat (2) expw = {expw[62:0], 1'b1};
    repeat (CLK_DIV) expw = {expw[62:0], 1'b0};
    for (int i = 0; i < 8; i++) repeat (CLK_DIV) expw = {expw[62:0], b[i]};
    repeat (CLK_DIV) expw = {expw[62:0], 1'b1};
    write_data(b);
    cap = '0;
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      cap = {cap[62:0], tx};
    end
    check("a5 waveform", cap, expw);
    wait_tx_drain;
    read_status;

    // Unmapped address and read-with-write are never driven
    tick;
    nce = 1'b0; noe = 1'b0; addr = BASE + 8'd2;
    @(negedge clk);
    check("unmapped busNOE", bus_noe, 1'b1);
    tick;
    addr = BASE + 8'd1; nwe = 1'b0; wdata = 8'hFF;
    @(negedge clk);
    check("rd+wr busNOE", bus_noe, 1'b1);
    tick;
    bus_idle;

    send_rx(8'h3C, 1'b1);
    check("irq after rx", irq_n, rx_model.size() == 0);
    read_data(1);
    read_data(1);
    read_status;

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    read_data(5);
    read_data(1);

    tick;
    rx = 1'b0;
    tick;
    rx = 1'b1;
    repeat (20) tick;
    check("glitch irq", irq_n, 1'b1);
    read_status;

    send_rx(8'($urandom), 1'b0);
    read_status;
    read_status;

    for (int i = 0; i < DEPTH + 1; i++) send_rx(8'($urandom), 1'b1);
    check("overrun irq", irq_n, rx_model.size() == 0);
    read_status;
    read_status;
    for (int i = 0; i < DEPTH + 1; i++) read_data(1);
    read_status;

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) write_data(8'($urandom));
      wait_tx_drain;
    end
    read_status;

    for (int r = 0; r < 8; r++) begin
      send_rx(8'($urandom), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 1) == 1) read_data($urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0) read_status;
    end
    check("random irq", irq_n, rx_model.size() == 0);
    while (rx_model.size() != 0) read_data(1);
    read_status;

    write_data(8'h5A);
    repeat (15) tick;
    apply_reset;
    @(negedge clk);
    check("mid-frame reset tx", tx, 1'b1);
    check("mid-frame reset busNOE", bus_noe, 1'b1);
    repeat (40) tick;
    check("post reset irq", irq_n, 1'b1);
    read_status;

    repeat (5) tick;
    check("reads drained", rd_exp_q.size(), 0);
    check("tx frames drained", tx_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
